// File: rtl/axi4_read_arbiter_n_if.sv
// AXI4-lite read channel bundle (AR + R) between the arbiter and the memory port.
interface axi4_read_arbiter_n_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          ar_valid;
    logic [AW-1:0] ar_addr;
    logic          ar_ready;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          r_ready;

    modport master (
        output ar_valid, ar_addr, r_ready,
        input  ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready,
        output ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi4_read_arbiter_n.sv
// N-channel round-robin read arbiter driving a single AXI4-lite read master,
// with R-phase timeout and draining of the late beat after a timeout.
module axi4_read_arbiter_n #(
    parameter  int NCH     = 2,
    parameter  int AW      = 64,
    parameter  int DW      = 64,
    parameter  int TIMEOUT = 256,
    localparam int IDW     = $clog2(NCH)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*AW-1:0]    addr,
    output logic [NCH-1:0]       finish,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_err,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    axi4_read_arbiter_n_if.master axi
);
    localparam int CW   = $clog2(TIMEOUT + 2);
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [AW-1:0]  ar_addr_q, ar_addr_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;
    logic           stale_q, stale_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [AW-1:0]  addr_ch [NCH];
    logic [IDW-1:0] pick, cand;
    logic           pick_vld;
    logic           timeout_hit;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_addr
        assign addr_ch[gi] = addr[gi*AW +: AW];
    end

    // Walk from farthest to nearest so the channel right after last wins.
    always_comb begin
        pick     = last_q;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = IDW'((int'(last_q) + 1 + k) % NCH);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Fires on the DATA cycle whose increment would reach TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt_q) + 1) >= TLIM);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        ar_addr_d    = ar_addr_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        stale_d      = stale_q;
        cnt_d        = cnt_q;
        finish       = '0;
        axi.ar_valid = 1'b0;
        axi.r_ready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld && !stale_q) begin
                    grant_d   = pick;
                    ar_addr_d = addr_ch[pick];
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                axi.ar_valid = 1'b1;
                if (axi.ar_ready) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                axi.r_ready = 1'b1;
                // A beat arriving on the timeout cycle still counts as a normal completion.
                if (axi.r_valid) begin
                    rsp_data_d = axi.r_data;
                    rsp_err_d  = (axi.r_resp != 2'b00);
                    state_d    = DONE;
                end else if (timeout_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    stale_d    = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                finish[grant_q] = 1'b1;
                last_d          = grant_q;
                state_d         = stale_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                axi.r_ready = 1'b1;
                if (axi.r_valid) begin
                    stale_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= IDW'(NCH - 1);
            ar_addr_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            stale_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            ar_addr_q  <= ar_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            stale_q    <= stale_d;
            cnt_q      <= cnt_d;
        end
    end

    assign axi.ar_addr = ar_addr_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: doc/axi4_read_arbiter_n.md
Name: axi4_read_arbiter_n

Overview:
- Parametrised N-channel read arbiter plus AXI4-lite read master.
- Sits between the requesters (instruction fetch, execute load, future DMA/debug) and one shared memory read port.
- Arbitrates with registered round-robin and runs a full AR/R handshake.
- Returns data and a per-channel finish pulse, with an error flag for bad responses and for timeouts.

Parameters:
NCH, 2, number of requester channels (>=2; channel 0 is highest priority out of reset)
AW, 64, address width
DW, 64, data width
TIMEOUT, 256, R-phase cycle limit before error completion; 0 disables the timeout
IDW, $clog2(NCH), localparam, grant index width

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
req  in  NCH  per-channel read request; held by the requester until its finish bit pulses
addr  in  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW]
finish  out  NCH  one-hot, one-cycle completion pulse to the granted channel
rsp_data  out  DW  read data; valid in the finish cycle and held until the next completion
rsp_err  out  1  error flag; valid with finish
grant_id  out  IDW  index of the channel currently or last served
busy  out  1  high whenever state is not IDLE
ar_valid  out  1  AXI read address valid
ar_addr  out  AW  AXI read address
ar_ready  in  1  AXI read address ready
r_valid  in  1  AXI read data valid
r_data  in  DW  AXI read data
r_resp  in  2  AXI read response; 2'b00 = OKAY, any other value is an error
r_ready  out  1  AXI read data ready

Behaviour:
- Reset (async, RST_N=0):
  - All outputs go to 0.
  - State = IDLE; last-grant pointer = NCH-1; timeout counter = 0; stale flag = 0.
  - Reset mid-transaction abandons it with no finish pulse.
- FSM states: IDLE, ADDR, DATA, DONE, DRAIN.
- IDLE:
  - If any req bit is set and stale=0, pick the first set bit searching last+1, last+2, ... with wrap modulo NCH.
  - Latch the index into grant_id and latch that channel's address slice into ar_addr; go to ADDR.
  - No request: stay in IDLE.
- ADDR:
  - ar_valid=1; ar_addr stays stable until ar_ready=1 (AXI rule: valid is never dropped before ready).
  - On ar_valid&ar_ready: ar_valid=0 next cycle, timeout counter cleared, go to DATA.
- DATA:
  - r_ready=1.
  - On r_valid: latch rsp_data=r_data and rsp_err=(r_resp!=0); go to DONE.
  - Otherwise increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without r_valid: rsp_data=0, rsp_err=1, stale=1, go to DONE.
- DONE:
  - finish[grant_id]=1 for exactly one cycle; last-grant pointer = grant_id.
  - Go to DRAIN if stale=1, else to IDLE.
- DRAIN:
  - r_ready=1; the first r_valid beat is discarded, stale cleared, go to IDLE. No new AR is issued until then.
- Timing:
  - Minimum latency with ar_ready already high and r_valid one cycle after the AR handshake: req sampled at cycle 0, AR handshake at cycle 1, R beat at cycle 2, finish at cycle 3.
  - Back-to-back transactions: IDLE follows DONE, so at most one transaction completes every 4 cycles.
- Request changes during a transaction:
  - req or addr changing after grant has no effect; the address is latched.
  - If the requester drops req mid-flight, the transaction still completes and finish still pulses.
- Simultaneous requests: only the round-robin order decides. A channel that just finished has lowest priority at the next arbitration.
- r_valid outside DATA/DRAIN is ignored (r_ready=0).
- r_valid landing in the same cycle the timeout fires: the data wins; it is a normal completion and stale stays 0.

Test Plan:
- Single channel: req[0]=1, addr0=0x8000_0000, ar_ready=1, r_valid one cycle after the AR handshake with r_data=0xDEAD_BEEF_0000_0001 -> finish=01 at cycle 3, rsp_data=0xDEAD_BEEF_0000_0001, rsp_err=0, ar_addr=0x8000_0000.
- Fairness: NCH=2, both req held high continuously -> grant order 0,1,0,1 over 4 transactions; finish alternates 01,10.
- Backpressure: ar_ready low for 5 cycles -> ar_valid and ar_addr stable all 5 cycles; r_valid delayed 7 cycles -> finish 7 cycles later than the minimum case.
- Error response: r_resp=2'b10, r_data=0x1234 -> rsp_err=1 with finish, rsp_data=0x1234.
- Timeout: TIMEOUT=8, no r_valid -> finish with rsp_err=1 and rsp_data=0 eight cycles after the AR handshake. A new req arriving meanwhile issues no AR until a late r_valid beat has been drained.
- Reset mid-DATA: RST_N low for 1 cycle -> all outputs 0 immediately; no finish pulse; the next req is served with channel 0 first.
